// File: rtl/prog_loader.sv
// Boot-time program loader: receives a framed byte stream (length, 16-bit words,
// XOR checksum), writes program memory from address 0, and releases the CPU on success.
module prog_loader #(
  parameter int unsigned AW   = 10,
  parameter int unsigned MAXW = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic          skip_load,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CHK,
    RUN,
    ERR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(MAXW);

  state_t      state;
  logic [15:0] len;
  logic [AW:0] idx;
  logic [7:0]  chk;
  logic [7:0]  hi;

  logic        accept;
  logic [15:0] len_n;
  logic [AW:0] idx_nx;

  always_comb begin
    unique case (state)
      LEN_HI:                    rx_ready = !skip_load;
      LEN_LO, DATA_HI, DATA_LO,
      CHK:                       rx_ready = 1'b1;
      default:                   rx_ready = 1'b0;
    endcase
  end

  assign accept = rx_valid && rx_ready;
  assign len_n  = {len[15:8], rx_data};
  assign idx_nx = idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= LEN_HI;
      len       <= '0;
      idx       <= '0;
      chk       <= '0;
      hi        <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        LEN_HI: begin
          // skip takes priority; rx_ready is already low so no byte is consumed
          if (skip_load) begin
            state    <= RUN;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end else if (accept) begin
            len[15:8] <= rx_data;
            chk       <= chk ^ rx_data;
            state     <= LEN_LO;
          end
        end
        LEN_LO: if (accept) begin
          len[7:0] <= rx_data;
          chk      <= chk ^ rx_data;
          if (len_n == '0) begin
            state <= CHK;
          end else if ({1'b0, len_n} > MAX_WORDS) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            state <= DATA_HI;
          end
        end
        DATA_HI: if (accept) begin
          hi    <= rx_data;
          chk   <= chk ^ rx_data;
          state <= DATA_LO;
        end
        DATA_LO: if (accept) begin
          chk       <= chk ^ rx_data;
          mem_we    <= 1'b1;
          mem_addr  <= idx[AW-1:0];
          mem_wdata <= {hi, rx_data};
          idx       <= idx_nx;
          state     <= (16'(idx_nx) == len) ? CHK : DATA_HI;
        end
        CHK: if (accept) begin
          if (rx_data == chk) begin
            state    <= RUN;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end else begin
            state <= ERR;
            err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued by the driver, popped by a
// negedge monitor on every mem_we pulse; status outputs checked with directed vectors.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic       skip_load = 1'b0;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [15:0] mem_wdata;
  logic       cpu_hold, done, err;

  int errors = 0;
  int checks = 0;
  logic [25:0] exp_q[$];

  prog_loader #(.AW(10), .MAXW(1024)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .skip_load(skip_load), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        logic [25:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          errors++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   mem_addr, mem_wdata, e[25:16], e[15:0]);
        end
      end
    end
  end

  // All driving happens at negedge; each put presents a byte across one rising edge.
  task automatic put(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    reset    = 1'b1;
    exp_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cpu_hold"}, int'(cpu_hold), 1);
    check({tag, "_done"},     int'(done), 0);
    check({tag, "_err"},      int'(err), 0);
    check({tag, "_mem_we"},   int'(mem_we), 0);
    check({tag, "_mem_addr"}, int'(mem_addr), 0);
    check({tag, "_wdata"},    int'(mem_wdata), 0);
    check({tag, "_rx_ready"}, int'(rx_ready), 1);
  endtask

  task automatic check_status(input string tag, input int d, input int e, input int h, input int r);
    check({tag, "_done"},     int'(done), d);
    check({tag, "_err"},      int'(err), e);
    check({tag, "_cpu_hold"}, int'(cpu_hold), h);
    check({tag, "_rx_ready"}, int'(rx_ready), r);
  endtask

  // Good image 00 02 12 34 AB CD 42, optional random idle gaps between bytes.
  task automatic send_good(input logic [7:0] last, input bit gaps);
    logic [7:0] img [7];
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, last};
    for (int i = 0; i < 7; i++) begin
      if (i == 3) exp_q.push_back({10'h000, 16'h1234});
      if (i == 5) exp_q.push_back({10'h001, 16'hABCD});
      put(img[i]);
      if (gaps) idle(int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    idle(2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_reset_state("rst");

    // Good image, back-to-back
    send_good(8'h42, 1'b0);
    check_status("good", 1, 0, 0, 0);
    check("good_q_empty", exp_q.size(), 0);
    put(8'h12); put(8'h34); idle(3);
    check_status("good_after", 1, 0, 0, 0);

    // Bad checksum
    do_reset();
    send_good(8'h43, 1'b0);
    check_status("badchk", 0, 1, 1, 0);
    put(8'h00); put(8'h01); put(8'h12); put(8'h34); idle(3);
    check("badchk_q_empty", exp_q.size(), 0);

    // Over-length
    do_reset();
    put(8'h04);
    put(8'h01);
    check_status("overlen", 0, 1, 1, 0);
    put(8'h12); put(8'h34); idle(2);

    // Zero length
    do_reset();
    put(8'h00); put(8'h00);
    check_status("zero_mid", 0, 0, 1, 1);
    put(8'h00);
    check_status("zero", 1, 0, 0, 0);
    idle(2);

    // Maximum length: 1024 words
    do_reset();
    begin
      logic [7:0]  c;
      logic [15:0] w;
      c = 8'h04;
      put(8'h04); put(8'h00);
      for (int unsigned i = 0; i < 1024; i++) begin
        w = 16'(i * 16'h0137) ^ 16'hA55A;
        c = c ^ w[15:8] ^ w[7:0];
        put(w[15:8]);
        exp_q.push_back({10'(i), w});
        put(w[7:0]);
      end
      check_status("max_pre", 0, 0, 1, 1);
      put(c);
      check_status("max", 1, 0, 0, 0);
      check("max_q_empty", exp_q.size(), 0);
    end

    // Idle gaps between bytes
    do_reset();
    send_good(8'h42, 1'b1);
    idle(1);
    check_status("gaps", 1, 0, 0, 0);
    check("gaps_q_empty", exp_q.size(), 0);

    // Reset mid-load, then reload
    do_reset();
    exp_q.push_back({10'h000, 16'h1234});
    put(8'h00); put(8'h02); put(8'h12); put(8'h34); put(8'hAB);
    check("mid_q_empty", exp_q.size(), 0);
    do_reset();
    check_reset_state("mid_rst");
    send_good(8'h42, 1'b0);
    check_status("reload", 1, 0, 0, 0);
    check("reload_q_empty", exp_q.size(), 0);

    // Skip in LEN_HI
    do_reset();
    skip_load = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b1;
    #1;
    check("skip_rx_ready", int'(rx_ready), 0);
    @(negedge clk);
    skip_load = 1'b0;
    rx_valid  = 1'b0;
    check_status("skip", 1, 0, 0, 0);
    idle(2);

    // Skip ignored in LEN_LO: image 00 01 12 34 chk=27
    do_reset();
    put(8'h00);
    skip_load = 1'b1;
    put(8'h01);
    skip_load = 1'b0;
    check_status("skiplo", 0, 0, 1, 1);
    put(8'h12);
    exp_q.push_back({10'h000, 16'h1234});
    put(8'h34);
    put(8'h27);
    check_status("skiplo_end", 1, 0, 0, 0);
    check("skiplo_q_empty", exp_q.size(), 0);

    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Boot-time program loader that sits directly upstream of the CPU's program memory.
- Receives a framed byte stream (length, 16-bit instruction words, checksum) over a valid/ready byte interface.
- Writes each word into program memory, starting at address 0.
- Holds the CPU in reset until the whole image is loaded and the checksum is verified, then releases it.
- After release the block is inert until the next reset.

Parameters:
AW, 10, program memory address width; must match the CPU's 10-bit PC.
MAXW, 1024, maximum accepted word count; must be ≤ 2^AW.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset; sampled on rising edge of clk
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data valid this cycle
rx_ready  out  1  loader can accept a byte; combinational from state and skip_load
skip_load  in  1  in LEN_HI only: release the CPU without loading; existing memory is kept
mem_we  out  1  program memory write enable, one-cycle pulse per word
mem_addr  out  AW  write address
mem_wdata  out  16  instruction word to write
cpu_hold  out  1  active-high; drives the CPU datapath reset; 1 until the load succeeds
done  out  1  1 once in RUN; sticky until reset
err  out  1  1 once in ERR; sticky until reset

Behaviour:
- Reset (reset=0 at an edge):
  - state←LEN_HI, idx←0, chk←0.
  - mem_we←0, mem_addr←0, mem_wdata←0, cpu_hold←1, done←0, err←0.
  - Applies mid-load too. Partially written memory is not cleared.
- Transfer: a byte is accepted on an edge where rx_valid=1 and rx_ready=1. Nothing else advances the FSM except skip_load in LEN_HI.
- rx_ready:
  - 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK.
  - 0 in RUN and ERR.
  - Forced to 0 in LEN_HI while skip_load=1.
- Checksum: chk ← chk XOR byte for every accepted byte except the checksum byte itself (length bytes and data bytes).
- FSM:
  - LEN_HI: accepting a byte latches N[15:8] → LEN_LO. If skip_load=1 → RUN; skip wins and no byte is accepted.
  - LEN_LO: accepting a byte latches N[7:0]. Then:
    - N=0 → CHK.
    - N>MAXW → ERR. No checksum is expected.
    - Otherwise → DATA_HI.
  - DATA_HI: accepting a byte latches hi → DATA_LO.
  - DATA_LO: accepting a byte registers a write:
    - Next cycle: mem_we=1, mem_addr=idx[AW-1:0], mem_wdata={hi,byte}.
    - idx←idx+1 (idx is 11 bits, so N=1024 does not wrap).
    - If the new idx equals N → CHK; else → DATA_HI.
  - CHK: accepting a byte compares it with chk.
    - Equal → RUN: cpu_hold←0, done←1.
    - Not equal → ERR: err←1, cpu_hold stays 1.
  - RUN, ERR: terminal until reset. All rx bytes are ignored.
- Latency:
  - mem_we is asserted exactly 1 cycle after the low byte is accepted and lasts 1 cycle.
  - Back-to-back bytes give writes every 2 cycles.
  - cpu_hold falls 1 cycle after the checksum byte is accepted. This is the same edge at which the final write's mem_we pulse has already completed, so the last word is always written before the CPU is released.
- Idle gaps (rx_valid=0) change nothing; mem_we stays 0.
- Byte order is big-endian throughout (length and data).

Test Plan:
- Good image: bytes 00 02 12 34 AB CD 42 back-to-back → mem_we pulses with (addr 0, 0x1234) then (addr 1, 0xABCD); cpu_hold=0 and done=1 one cycle after 0x42 is accepted; rx_ready=0 thereafter.
- Bad checksum: same image with final byte 0x43 → both writes occur, then err=1, cpu_hold stays 1, done=0, rx_ready=0; further bytes cause no mem_we.
- Length bounds:
  - 04 01 → err=1 right after the second byte, no writes.
  - 00 00 00 → done=1, no mem_we.
  - 04 00 followed by 1024 words and the correct chk → last write at addr 0x3FF, done=1.
- Backpressure/gaps: the good image with rx_valid deasserted randomly between bytes → identical write sequence and values; no spurious mem_we.
- Reset mid-load: after 00 02 12 34 AB, pulse reset=0 for one cycle → outputs at reset values; resending the full good image gives done=1 with the correct writes.
- Skip: skip_load=1 in LEN_HI with rx_valid=1 → no byte accepted, done=1, cpu_hold=0 next cycle, no mem_we; skip_load=1 in LEN_LO is ignored.
